// File: rtl/one_hot_pkg.sv
// one_hot_pkg: shared widths and error-counter limits for the one-hot decoder
package one_hot_pkg;
  localparam int BIN_W_D = 4;
  localparam int ONE_HOT_W_D = 16;
  localparam int ERR_CNT_W = 8;
  localparam int ERR_CNT_MAX = 255;
endpackage

// File: rtl/one_hot_dec_core.sv
// one_hot_dec_core: lowest-set-bit encoder with exactly-one-hot check
module one_hot_dec_core import one_hot_pkg::*; #(
  parameter int BIN_W = BIN_W_D,
  parameter int ONE_HOT_W = ONE_HOT_W_D
) (
  input  logic [ONE_HOT_W-1:0] word,
  output logic [BIN_W-1:0]     index,
  output logic                 err
);
  always_comb begin
    index = '0;
    for (int i = ONE_HOT_W - 1; i >= 0; i--) index = word[i] ? BIN_W'(i) : index;
  end
  assign err = ~|word || |(word & (word - ONE_HOT_W'(1)));
endmodule

// File: rtl/one_hot_dec.sv
// one_hot_dec: two-stage valid/ready pipeline decoding one-hot words with an error counter
module one_hot_dec import one_hot_pkg::*; #(
  parameter int BIN_W = BIN_W_D,
  parameter int ONE_HOT_W = ONE_HOT_W_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 cnt_clr_i
);
  logic                 s1_valid;
  logic [ONE_HOT_W-1:0] s1_word;
  logic [BIN_W-1:0]     core_index;
  logic                 core_err;
  logic                 s2_load;
  one_hot_dec_core #(.BIN_W(BIN_W), .ONE_HOT_W(ONE_HOT_W)) u_core (
    .word(s1_word),
    .index(core_index),
    .err(core_err)
  );
  assign s2_load = s1_valid && (!out_valid_o || out_ready_i);
  assign in_ready_o = !s1_valid || s2_load;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_word <= '0;
      out_valid_o <= 1'b0;
      bin_o <= '0;
      err_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      if (in_ready_o) s1_valid <= in_valid_i;
      if (in_ready_o && in_valid_i) s1_word <= one_hot_i;
      out_valid_o <= s2_load || (out_valid_o && !out_ready_i);
      if (s2_load) begin
        bin_o <= core_index;
        err_o <= core_err;
      end
      if (cnt_clr_i) err_cnt_o <= '0;
      else if (s2_load && core_err && err_cnt_o != ERR_CNT_W'(ERR_CNT_MAX)) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_one_hot_dec.sv
// tb_one_hot_dec: directed and random checks of the one-hot decoder pipeline
module tb_one_hot_dec;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] one_hot_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [3:0]  bin_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;
  logic        cnt_clr_i = 1'b0;
  int tests = 0;
  int fails = 0;

  one_hot_dec dut (
    .clk(clk),
    .reset(reset),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .one_hot_i(one_hot_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .bin_o(bin_o),
    .err_o(err_o),
    .err_cnt_o(err_cnt_o),
    .cnt_clr_i(cnt_clr_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int q[$];
    int sent, got, cyc, k, e;
    tick();
    tick();
    check("rst_valid", out_valid_o, 0);
    check("rst_bin", bin_o, 0);
    check("rst_err", err_o, 0);
    check("rst_cnt", err_cnt_o, 0);
    reset = 1'b0;
    #1;
    check("rst_ready", in_ready_o, 1);
    in_valid_i = 1'b1; one_hot_i = 16'h0001; tick();
    check("lat_not_yet", out_valid_o, 0);
    one_hot_i = 16'h0080; tick();
    check("str0_valid", out_valid_o, 1);
    check("str0_bin", bin_o, 0);
    check("str0_err", err_o, 0);
    one_hot_i = 16'h8000; tick();
    check("str1_bin", bin_o, 7);
    in_valid_i = 1'b0; tick();
    check("str2_bin", bin_o, 15);
    check("str2_err", err_o, 0);
    tick();
    check("idle_valid", out_valid_o, 0);
    check("idle_hold_bin", bin_o, 15);
    check("str_cnt", err_cnt_o, 0);
    in_valid_i = 1'b1; one_hot_i = 16'h0000; tick();
    one_hot_i = 16'h0A00; tick();
    check("zero_bin", bin_o, 0);
    check("zero_err", err_o, 1);
    in_valid_i = 1'b0; tick();
    check("multi_bin", bin_o, 9);
    check("multi_err", err_o, 1);
    check("mal_cnt", err_cnt_o, 2);
    tick();
    out_ready_i = 1'b0; in_valid_i = 1'b1; one_hot_i = 16'h0008; tick();
    one_hot_i = 16'h0020; tick();
    check("bp_valid", out_valid_o, 1);
    check("bp_bin", bin_o, 3);
    check("bp_ready", in_ready_o, 0);
    one_hot_i = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", out_valid_o, 1);
      check("bp_hold_bin", bin_o, 3);
      check("bp_hold_ready", in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    #1;
    check("bp_ready_comb", in_ready_o, 1);
    tick();
    check("bp_rel0", bin_o, 5);
    in_valid_i = 1'b0; tick();
    check("bp_rel1", bin_o, 6);
    check("bp_rel1_valid", out_valid_o, 1);
    tick();
    check("bp_drained", out_valid_o, 0);
    check("bp_cnt", err_cnt_o, 2);
    in_valid_i = 1'b1; one_hot_i = 16'h0000;
    for (int i = 0; i < 300; i++) tick();
    in_valid_i = 1'b0; tick(); tick(); tick();
    check("sat_cnt", err_cnt_o, 255);
    in_valid_i = 1'b1; one_hot_i = 16'h0000; tick();
    in_valid_i = 1'b0; cnt_clr_i = 1'b1; tick();
    cnt_clr_i = 1'b0;
    check("clr_win", err_cnt_o, 0);
    tick();
    check("clr_stay", err_cnt_o, 0);
    out_ready_i = 1'b0; in_valid_i = 1'b1; one_hot_i = 16'h0003; tick();
    one_hot_i = 16'h0200; tick();
    check("pre_rst_valid", out_valid_o, 1);
    check("pre_rst_cnt", err_cnt_o, 1);
    check("pre_rst_ready", in_ready_o, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid_o, 0);
    check("arst_cnt", err_cnt_o, 0);
    check("arst_bin", bin_o, 0);
    check("arst_err", err_o, 0);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_ready", in_ready_o, 1);
    tick(); tick();
    check("no_stale", out_valid_o, 0);
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      k = $urandom_range(0, 15);
      in_valid_i = (sent < 1000) && ($urandom_range(0, 3) != 0);
      one_hot_i = 16'(1) << k;
      out_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (out_valid_o && out_ready_i) begin
        e = (q.size() > 0) ? q.pop_front() : -1;
        check("rnd_bin", {28'd0, bin_o}, e);
        check("rnd_err", err_o, 0);
        got++;
      end
      if (in_valid_i && in_ready_o) begin
        q.push_back(k);
        sent++;
      end
      tick();
      cyc++;
    end
    check("rnd_count", got, 1000);
    check("rnd_cnt", err_cnt_o, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/one_hot_dec.md
ONE_HOT_DEC -- requirements
Module: one_hot_dec

Interface
REQ-001 Parameter BIN_W, default 4, is the width of the binary output index.
REQ-002 Parameter ONE_HOT_W, default 16, is the width of the one-hot input word and SHALL equal 2**BIN_W.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  is the asynchronous, active-high reset.
REQ-005 in_valid_i  input  1  indicates that the upstream word is valid.
REQ-006 in_ready_o  output  1  indicates that the block accepts a word this cycle.
REQ-007 one_hot_i  input  ONE_HOT_W  carries the one-hot coded input word.
REQ-008 out_valid_o  output  1  indicates that the decoded result is valid.
REQ-009 out_ready_i  input  1  indicates that downstream accepts the result this cycle.
REQ-010 bin_o  output  BIN_W  carries the decoded binary index.
REQ-011 err_o  output  1  flags that the word accompanying bin_o was not exactly one-hot.
REQ-012 err_cnt_o  output  8  holds the saturating count of accepted malformed words.
REQ-013 cnt_clr_i  input  1  is a synchronous clear for err_cnt_o.

Function
REQ-014 A word SHALL be accepted on any clk edge where in_valid_i and in_ready_o are both 1, and a result SHALL be consumed where out_valid_o and out_ready_i are both 1.
REQ-015 The block SHALL be a 2-stage pipeline: S1 registers one_hot_i, S2 registers bin_o/err_o, and out_valid_o is S2-valid.
REQ-016 Latency SHALL be 2 cycles: a word accepted at edge N is presented at edge N+2 when there is no backpressure.
REQ-017 Throughput SHALL be 1 word/cycle while out_ready_i=1.
REQ-018 S2 SHALL load when S1 is valid and (S2 is empty or S2 is consumed in the same cycle); in_ready_o = !S1_valid || S2_load.
REQ-019 in_ready_o SHALL be combinational from out_ready_i and state only, never from in_valid_i.
REQ-020 While out_valid_o=1 and out_ready_i=0, bin_o, err_o and out_valid_o SHALL hold stable.
REQ-021 For an exactly one-hot word with bit k set: bin_o=k, err_o=0.
REQ-022 For an all-zero word: bin_o=0, err_o=1.
REQ-023 For a multi-hot word: bin_o=index of the lowest set bit, err_o=1.
REQ-024 err_cnt_o SHALL increment by 1 when an S1 word with an error is loaded into S2, and SHALL saturate at 255.
REQ-025 When cnt_clr_i=1, err_cnt_o SHALL become 0 on the next edge; clear wins over a simultaneous increment.
REQ-026 With no words pending, out_valid_o=0 and bin_o/err_o SHALL hold their last values.

Reset
REQ-027 Asserting reset SHALL immediately force S1-valid=0, out_valid_o=0, bin_o=0, err_o=0 and err_cnt_o=0.
REQ-028 Reset mid-operation SHALL discard in-flight words with no partial output.
REQ-029 After reset deasserts, in_ready_o SHALL be 1 on the first cycle.

Structure
REQ-030 Package one_hot_pkg SHALL hold the BIN_W/ONE_HOT_W defaults and the error-counter width (8) and saturation constant (255).
REQ-031 The combinational encode and validity check SHALL live in sub-module one_hot_dec_core (in: word; out: index, err); the top level holds the pipeline, handshake and counter.

Verification
REQ-032 Streaming, out_ready_i=1: inputs 0x0001, 0x0080, 0x8000 on consecutive cycles -> bin_o 0, 7, 15 on cycles N+2..N+4, err_o=0, err_cnt_o=0.
REQ-033 Malformed: inputs 0x0000 and then 0x0A00 -> (bin_o=0, err_o=1), then (bin_o=9, err_o=1); err_cnt_o=2.
REQ-034 Backpressure: out_ready_i=0 for 5 cycles with continuous input -> exactly 2 words held, in_ready_o=0, outputs stable; release -> in-order delivery with no loss or duplication.
REQ-035 Saturation/clear: 300 malformed words -> err_cnt_o=255; cnt_clr_i coincident with an error -> err_cnt_o=0.
REQ-036 Reset mid-stream: assert reset with both stages full -> out_valid_o=0 and err_cnt_o=0 immediately, with no stale output after release.
REQ-037 Random: 1000 random one-hot words with random out_ready_i -> bin_o matches the index of each word in order.
